wb_host: RTL
============

WB_HOST -- requirements
Module: wb_host

Interface
REQ-001 SHALL have parameter ADR_W, default 3: Wishbone word-address width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 15: maximum ack wait in BUS state, range 1..255.
REQ-003 SHALL have port clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_in  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cmd_valid_i  in  1  command offered.
REQ-006 SHALL have port cmd_ready_o  out  1  command accepted when high with cmd_valid_i.
REQ-007 SHALL have ports cmd_we_i in 1, cmd_adr_i in ADR_W, cmd_be_i in 4, cmd_dat_i in 32: command fields.
REQ-008 SHALL have ports rsp_valid_o out 1, rsp_ready_i in 1: response handshake.
REQ-009 SHALL have ports rsp_dat_o out 32 (read data), rsp_err_o out 1 (timeout flag).
REQ-010 SHALL have ports wb_cyc_o, wb_stb_o, wb_we_o out 1; wb_adr_o out ADR_W; wb_be_o out 4; wb_dat_o out 32: Wishbone initiator outputs.
REQ-011 SHALL have ports wb_ack_i in 1, wb_dat_i in 32: Wishbone responder inputs.
REQ-012 SHALL have port busy_o  out  1  high whenever state is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, BUS, RSP.
REQ-014 IDLE: cmd_ready_o=1; cmd_valid_i&cmd_ready_o registers we/adr/be/dat and moves to BUS next cycle.
REQ-015 cmd_ready_o SHALL be 0 in BUS and RSP; no command buffering beyond one.
REQ-016 BUS: wb_cyc_o=wb_stb_o=1, wb_we_o/adr/be/dat driven from registered command, stable whole state.
REQ-017 BUS with wb_ack_i=1: capture wb_dat_i into rsp_dat_o on reads, rsp_dat_o=0 on writes, rsp_err_o=0, go RSP; cyc/stb drop next cycle.
REQ-018 Latency: command accepted cycle N, cyc/stb high N+1; combinational-ack responder acks N+1, rsp_valid_o high N+2.
REQ-019 BUS timeout counter SHALL clear on BUS entry, increment each BUS cycle without ack.
REQ-020 Counter reaching TIMEOUT_CYCLES without ack: drop cyc/stb, rsp_dat_o=0, rsp_err_o=1, go RSP.
REQ-021 Ack in the same cycle the timeout fires: ack wins, rsp_err_o=0.
REQ-022 RSP: rsp_valid_o=1, rsp_dat_o/rsp_err_o stable until rsp_valid_o&rsp_ready_i, then IDLE.
REQ-023 rsp_ready_i held high: back-to-back commands SHALL sustain one transaction per 3 cycles.
REQ-024 wb_ack_i outside BUS SHALL be ignored.
REQ-025 wb_stb_o SHALL never be high while wb_cyc_o is low.

Reset
REQ-026 rst_in low SHALL immediately (asynchronously) force IDLE, wb_cyc_o=wb_stb_o=wb_we_o=0, rsp_valid_o=0, rsp_err_o=0, busy_o=0.
REQ-027 Reset SHALL clear rsp_dat_o, wb_adr_o, wb_be_o, wb_dat_o, timeout counter to 0.
REQ-028 Reset mid-BUS or mid-RSP SHALL abort the transaction with no response emitted after release.
REQ-029 cmd_ready_o SHALL be 1 on the first rising edge after rst_in rises.

Configuration
REQ-030 Macro WB_HOST_TIMEOUT_EN defined: REQ-019..REQ-021 timeout logic compiled in.
REQ-031 WB_HOST_TIMEOUT_EN undefined: no counter; BUS waits indefinitely for ack; rsp_err_o tied 0; TIMEOUT_CYCLES ignored.

Verification
REQ-032 Write adr=0, be=4'b0001, dat=32'h0000_002A, ack same cycle as stb -> one cyc/stb cycle with we=1, rsp_valid_o at N+2, rsp_dat_o=0, rsp_err_o=0.
REQ-033 Read adr=1, responder returns 32'h0000_0015 with ack after 3 wait cycles -> cyc/stb high 4 cycles, rsp_dat_o=32'h0000_0015.
REQ-034 With WB_HOST_TIMEOUT_EN, TIMEOUT_CYCLES=15, no ack -> cyc/stb drop after 15 BUS cycles, rsp_err_o=1, rsp_dat_o=0; ack at cycle 15 -> rsp_err_o=0.
REQ-035 rsp_ready_i low 5 cycles after read -> rsp_valid_o and rsp_dat_o held 5 cycles, cmd_ready_o=0 throughout, IDLE after handshake.
REQ-036 rst_in pulsed low during BUS -> cyc/stb low same cycle, no rsp_valid_o after release, cmd_ready_o=1 next edge.
REQ-037 Three back-to-back commands, rsp_ready_i=1, zero-wait responder -> three responses exactly 3 cycles apart, in order.

Source files
------------

// File: rtl/wb_host.sv
// wb_host: single-outstanding command to Wishbone classic-cycle initiator with a response handshake.
// Define WB_HOST_TIMEOUT_EN to compile in the BUS-state ack timeout (TIMEOUT_CYCLES).
module wb_host #(
    parameter int unsigned ADR_W          = 3,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic             clk_i,
    input  logic             rst_in,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_we_i,
    input  logic [ADR_W-1:0] cmd_adr_i,
    input  logic [3:0]       cmd_be_i,
    input  logic [31:0]      cmd_dat_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_dat_o,
    output logic             rsp_err_o,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    output logic             wb_we_o,
    output logic [ADR_W-1:0] wb_adr_o,
    output logic [3:0]       wb_be_o,
    output logic [31:0]      wb_dat_o,
    input  logic             wb_ack_i,
    input  logic [31:0]      wb_dat_i,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RSP
    } state_t;

    state_t             r_state;
    logic               r_cyc;
    logic               r_we;
    logic [ADR_W-1:0]   r_adr;
    logic [3:0]         r_be;
    logic [31:0]        r_dat;
    logic               r_rsp_valid;
    logic [31:0]        r_rsp_dat;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("wb_host: TIMEOUT_CYCLES must be in 1..255");
    end

`ifdef WB_HOST_TIMEOUT_EN
    logic [7:0] r_tmo_cnt;
    logic       r_rsp_err;
    logic       w_tmo_hit;

    // Fires in the BUS cycle whose count would reach TIMEOUT_CYCLES; ack in that cycle still wins.
    assign w_tmo_hit = ((r_tmo_cnt + 8'd1) == 8'(TIMEOUT_CYCLES));
    assign rsp_err_o = r_rsp_err;
`else
    assign rsp_err_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            r_state     <= IDLE;
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_adr       <= '0;
            r_be        <= '0;
            r_dat       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= '0;
`ifdef WB_HOST_TIMEOUT_EN
            r_tmo_cnt   <= '0;
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        r_we    <= cmd_we_i;
                        r_adr   <= cmd_adr_i;
                        r_be    <= cmd_be_i;
                        r_dat   <= cmd_dat_i;
                        r_cyc   <= 1'b1;
                        r_state <= BUS;
`ifdef WB_HOST_TIMEOUT_EN
                        r_tmo_cnt <= '0;
`endif
                    end
                end
                BUS: begin
                    if (wb_ack_i) begin
                        r_rsp_dat   <= r_we ? '0 : wb_dat_i;
                        r_cyc       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RSP;
`ifdef WB_HOST_TIMEOUT_EN
                        r_rsp_err   <= 1'b0;
                    end else if (w_tmo_hit) begin
                        r_rsp_dat   <= '0;
                        r_rsp_err   <= 1'b1;
                        r_cyc       <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RSP;
                    end else begin
                        r_tmo_cnt   <= r_tmo_cnt + 8'd1;
`endif
                    end
                end
                RSP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_cyc       <= 1'b0;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    // cyc and stb share one register so stb can never be high without cyc.
    assign wb_cyc_o    = r_cyc;
    assign wb_stb_o    = r_cyc;
    assign wb_we_o     = r_we;
    assign wb_adr_o    = r_adr;
    assign wb_be_o     = r_be;
    assign wb_dat_o    = r_dat;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_dat_o   = r_rsp_dat;
    assign cmd_ready_o = (r_state == IDLE);
    assign busy_o      = (r_state != IDLE);

endmodule
